ram_arbiter: RTL
================

# ram_arbiter

Shares the single data RAM between the pipeline's data-memory port (CPU) and a secondary bus master (DMA / program loader / debug) inside the SoC top. The CPU has default priority. A starvation counter forces a bounded DMA burst and stalls the CPU through its hold input. The block is inserted between the core's ram_* ports and the RAM, and the CPU hold pin is driven by it.

## Interface
- ADDR_W, 32, address width of both masters and the RAM
- DATA_W, 32, data width
- STARVE_LIMIT, 8, consecutive cycles a DMA request may be refused before the CPU is stalled
- BURST_MAX, 4, maximum consecutive forced DMA grants per starvation event
- clk_100MHz  input  1  single clock, all state rising-edge
- arst  input  1  reset, asynchronous and active-high
- cpu_r_ena_i  input  1  CPU read strobe
- cpu_r_addr_i  input  ADDR_W  CPU read address
- cpu_w_ena_i  input  1  CPU write strobe
- cpu_w_addr_i  input  ADDR_W  CPU write address
- cpu_w_data_i  input  DATA_W  CPU write data
- cpu_r_data_o  output  DATA_W  ram_r_data_i passed through
- cpu_hold_o  output  1  stall request to pipeline hold
- dma_req_i  input  1  DMA access request, held until granted
- dma_we_i  input  1  1 = write, 0 = read
- dma_addr_i  input  ADDR_W  DMA address
- dma_wdata_i  input  DATA_W  DMA write data
- dma_gnt_o  output  1  access performed this cycle
- dma_rvalid_o  output  1  registered read-data valid pulse
- dma_rdata_o  output  DATA_W  registered DMA read data
- ram_r_ena_o, ram_r_addr_o, ram_w_ena_o, ram_w_addr_o, ram_w_data_o  output  1/ADDR_W/1/ADDR_W/DATA_W  RAM port
- ram_r_data_i  input  DATA_W  RAM read data, combinational in the same cycle as ram_r_ena_o

## Operation
- cpu_acc = cpu_r_ena_i | cpu_w_ena_i.
- FSM states:
  - S_CPU (reset state).
  - S_BURST.
- Owner in S_CPU:
  - DMA owns the cycle if dma_req_i & (!cpu_acc | starve_cnt == STARVE_LIMIT).
  - Otherwise the CPU owns it.
- Owner in S_BURST: DMA owns the cycle while dma_req_i = 1.
- DMA owner:
  - dma_gnt_o = 1.
  - The RAM port carries the DMA access. A read drives r_ena/r_addr; a write drives w_ena/w_addr/w_data.
  - The other RAM strobe is 0.
  - cpu_hold_o = cpu_acc.
- CPU owner:
  - The RAM port mirrors the CPU inputs unmodified.
  - dma_gnt_o = 0 and cpu_hold_o = 0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) in each cycle where dma_req_i = 1 and dma_gnt_o = 0.
  - Clears on any grant or when dma_req_i = 0.
- Transitions:
  - S_CPU -> S_BURST when a grant is taken with starve_cnt == STARVE_LIMIT and cpu_acc = 1. burst_cnt is loaded to 1.
  - S_BURST: each grant increments burst_cnt.
  - S_BURST -> S_CPU when dma_req_i = 0, or when a grant occurs with burst_cnt == BURST_MAX. The final grant is still performed.
- Idle-slot grants in S_CPU (cpu_acc = 0) never enter S_BURST and never stall the CPU.
- DMA read data:
  - On a granted read, dma_rdata_o <= ram_r_data_i at the clock edge.
  - dma_rvalid_o pulses 1 in the following cycle.
  - dma_rdata_o holds its value otherwise.
- Reset mid-burst: returns immediately to S_CPU, clears all counters, and drops dma_rvalid_o. An in-flight DMA read is lost, and the DMA master must re-request.

## Timing
- Reset values:
  - State S_CPU; starve_cnt = 0; burst_cnt = 0.
  - dma_rvalid_o = 0; dma_rdata_o = 0.
  - Combinational outputs are 0 when all inputs are 0.
- Grant, hold and RAM muxing are combinational from the current inputs and registered state, so there are zero cycles of added latency for either master.
- DMA handshake: the transfer completes in the cycle with dma_req_i & dma_gnt_o. The master updates address and data on the next edge.
- Read latency for DMA: 1 cycle, from the grant cycle to dma_rvalid_o.
- Worst-case DMA wait under a continuous CPU load is STARVE_LIMIT cycles. Worst-case CPU stall is BURST_MAX cycles per starvation event.
- Simultaneous events:
  - A CPU access and an eligible DMA request in the same cycle: exactly one reaches the RAM. A dropped CPU access is always covered by cpu_hold_o = 1.

## Test plan
Bench parameters: STARVE_LIMIT = 4, BURST_MAX = 2.
- Reset: assert arst mid-cycle -> all outputs 0 asynchronously, state S_CPU.
- CPU only: a CPU read of 0x10 with RAM returning 0xDEADBEEF -> ram_r_addr_o = 0x10, cpu_r_data_o = 0xDEADBEEF, cpu_hold_o = 0.
- Idle-slot DMA: cpu_acc = 0, DMA write of 0x1234 to 0x20 -> dma_gnt_o = 1 in the same cycle, ram_w_ena_o = 1, no hold.
- Starvation: continuous cpu_acc = 1 with DMA read requests -> gnt refused for 4 cycles. Then 2 grants follow with cpu_hold_o = 1, and the 3rd cycle returns to the CPU.
- DMA read data: a grant read at 0x40 with RAM returning 0xCAFE0001 -> the next cycle has dma_rvalid_o = 1, dma_rdata_o = 0xCAFE0001.
- Reset during S_BURST: arst asserted after the first forced grant -> hold drops, counters are 0, and the CPU owns the next cycle.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single data RAM between the CPU data-memory port
// and a secondary bus master (DMA / loader / debug). The CPU wins by default.
// A DMA request refused for STARVE_LIMIT consecutive cycles forces a short
// DMA burst, and the CPU is held off while that burst takes its slots.
module ram_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4
) (
    input  logic              clk_100MHz,
    input  logic              arst,
    // CPU data-memory port
    input  logic              cpu_r_ena_i,
    input  logic [ADDR_W-1:0] cpu_r_addr_i,
    input  logic              cpu_w_ena_i,
    input  logic [ADDR_W-1:0] cpu_w_addr_i,
    input  logic [DATA_W-1:0] cpu_w_data_i,
    output logic [DATA_W-1:0] cpu_r_data_o,
    output logic              cpu_hold_o,
    // secondary master
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_gnt_o,
    output logic              dma_rvalid_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    // RAM port
    output logic              ram_r_ena_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    output logic              ram_w_ena_o,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_w_data_o,
    input  logic [DATA_W-1:0] ram_r_data_i
);

    // Counter widths: wide enough to hold their limit values.
    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int BC_W = (BURST_MAX < 1) ? 1 : $clog2(BURST_MAX + 1);

    localparam logic [SC_W-1:0] STARVE_TOP  = SC_W'(STARVE_LIMIT);
    localparam logic [SC_W-1:0] STARVE_ONE  = SC_W'(1);
    localparam logic [SC_W-1:0] STARVE_ZERO = SC_W'(0);
    localparam logic [BC_W-1:0] BURST_TOP   = BC_W'(BURST_MAX);
    localparam logic [BC_W-1:0] BURST_ONE   = BC_W'(1);
    localparam logic [BC_W-1:0] BURST_ZERO  = BC_W'(0);

    // With a burst length of one, the forced grant taken in S_CPU is already
    // the whole burst, so S_BURST is never entered.
    localparam logic BURST_MULTI = (BURST_MAX > 1) ? 1'b1 : 1'b0;

    // FSM encoding
    localparam logic [0:0] S_CPU   = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]      state_r;
    logic [0:0]      state_nxt_s;
    logic [SC_W-1:0] starve_cnt_r;
    logic [SC_W-1:0] starve_nxt_s;
    logic [BC_W-1:0] burst_cnt_r;
    logic [BC_W-1:0] burst_nxt_s;

    logic              cpu_acc_s;
    logic              starve_hit_s;
    logic              dma_own_s;
    logic              burst_last_s;
    logic              dma_rd_gnt_s;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_r;

    assign cpu_acc_s    = cpu_r_ena_i | cpu_w_ena_i;
    assign starve_hit_s = (starve_cnt_r == STARVE_TOP);
    // burst_cnt_r counts forced grants already taken; the grant that brings
    // the total to BURST_MAX is the last one of the burst.
    assign burst_last_s = ((burst_cnt_r + BURST_ONE) >= BURST_TOP);
    assign dma_rd_gnt_s = dma_own_s & ~dma_we_i;

    // Decide which master owns the RAM in the current cycle.
    always_comb begin
        dma_own_s = 1'b0;
        case (state_r)
            S_CPU: begin
                if (dma_req_i && (!cpu_acc_s || starve_hit_s)) begin
                    dma_own_s = 1'b1;
                end else begin
                    dma_own_s = 1'b0;
                end
            end
            S_BURST: begin
                dma_own_s = dma_req_i;
            end
            default: begin
                dma_own_s = 1'b0;
            end
        endcase
    end

    // Steer the RAM port to the owning master and raise hold on a lost CPU access.
    always_comb begin
        ram_r_ena_o  = cpu_r_ena_i;
        ram_r_addr_o = cpu_r_addr_i;
        ram_w_ena_o  = cpu_w_ena_i;
        ram_w_addr_o = cpu_w_addr_i;
        ram_w_data_o = cpu_w_data_i;
        dma_gnt_o    = 1'b0;
        cpu_hold_o   = 1'b0;
        if (dma_own_s) begin
            ram_r_ena_o  = ~dma_we_i;
            ram_r_addr_o = dma_addr_i;
            ram_w_ena_o  = dma_we_i;
            ram_w_addr_o = dma_addr_i;
            ram_w_data_o = dma_wdata_i;
            dma_gnt_o    = 1'b1;
            cpu_hold_o   = cpu_acc_s;
        end else begin
            dma_gnt_o  = 1'b0;
            cpu_hold_o = 1'b0;
        end
    end

    // Starvation counter: counts refused request cycles, saturating at the limit.
    always_comb begin
        starve_nxt_s = STARVE_ZERO;
        if (dma_req_i && !dma_own_s) begin
            if (starve_hit_s) begin
                starve_nxt_s = starve_cnt_r;
            end else begin
                starve_nxt_s = starve_cnt_r + STARVE_ONE;
            end
        end else begin
            starve_nxt_s = STARVE_ZERO;
        end
    end

    // Next-state and burst-length logic.
    always_comb begin
        state_nxt_s = state_r;
        burst_nxt_s = burst_cnt_r;
        case (state_r)
            S_CPU: begin
                // Only a forced grant that actually displaces the CPU starts a burst.
                if (dma_own_s && cpu_acc_s && starve_hit_s && BURST_MULTI) begin
                    state_nxt_s = S_BURST;
                    burst_nxt_s = BURST_ONE;
                end else begin
                    state_nxt_s = S_CPU;
                    burst_nxt_s = BURST_ZERO;
                end
            end
            S_BURST: begin
                if (!dma_req_i) begin
                    state_nxt_s = S_CPU;
                    burst_nxt_s = BURST_ZERO;
                end else if (burst_last_s) begin
                    state_nxt_s = S_CPU;
                    burst_nxt_s = BURST_ZERO;
                end else begin
                    state_nxt_s = S_BURST;
                    burst_nxt_s = burst_cnt_r + BURST_ONE;
                end
            end
            default: begin
                state_nxt_s = S_CPU;
                burst_nxt_s = BURST_ZERO;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            state_r      <= S_CPU;
            starve_cnt_r <= STARVE_ZERO;
            burst_cnt_r  <= BURST_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    // Capture DMA read data on a granted read; valid pulses the following cycle.
    always_ff @(posedge clk_100MHz or posedge arst) begin
        if (arst) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
        end else begin
            rvalid_r <= dma_rd_gnt_s;
            if (dma_rd_gnt_s) begin
                rdata_r <= ram_r_data_i;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign dma_rvalid_o = rvalid_r;
    assign dma_rdata_o  = rdata_r;
    assign cpu_r_data_o = ram_r_data_i;

endmodule
